// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port request/grant arbiter sharing one synchronous-write RAM,
// fixed-priority with a starvation guard or round-robin, one access per two cycles.
module ram_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int RR_MODE  = 0,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_oe,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t            state;
   logic              sel, last_grant, cmd_we, win1;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [3:0]        wait_cnt;
   // port 1 wins a tie when it is its turn (RR) or it has lost MAX_WAIT times in a row
   always_comb win1 = (req0 && req1) ? (RR_MODE != 0 ? !last_grant : wait_cnt == 4'(MAX_WAIT)) : req1;
   assign mem_addr  = cmd_addr;
   assign mem_wdata = cmd_wdata;
   assign mem_we    = state == ACCESS && cmd_we;
   assign mem_oe    = state == ACCESS && !cmd_we;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         sel        <= 1'b0;
         last_grant <= 1'b1;
         wait_cnt   <= '0;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         busy       <= 1'b0;
      end else begin
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         if (state == IDLE) begin
            if (req0 || req1) begin
               state      <= ACCESS;
               busy       <= 1'b1;
               sel        <= win1;
               last_grant <= win1;
               gnt0       <= !win1;
               gnt1       <= win1;
               cmd_we     <= win1 ? we1 : we0;
               cmd_addr   <= win1 ? addr1 : addr0;
               cmd_wdata  <= win1 ? wdata1 : wdata0;
            end
            wait_cnt <= (!req1 || win1) ? 4'd0 : (wait_cnt == 4'd15 ? wait_cnt : wait_cnt + 4'd1);
         end else begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!cmd_we && !sel) begin
               rvalid0 <= 1'b1;
               rdata0  <= mem_rdata;
            end
            if (!cmd_we && sel) begin
               rvalid1 <= 1'b1;
               rdata1  <= mem_rdata;
            end
         end
      end
   end
endmodule
